kernel_cc_start_arbiter: RTL and testbench
==========================================

Name: kernel_cc_start_arbiter

Overview:
- Round-robin scheduler that shares one HLS dataflow process (ap_start/ap_ready/ap_done block-level handshake) among N upstream producers.
- Each producer signals work through its own 1-bit start-token FIFO. The arbiter pops one token, runs the shared process once, then pushes the served requester's ID into a downstream start/ID FIFO.
- Sits between the per-PE start_for_* FIFOs and the shared write-back stage of the kernel_cc dataflow region.

Parameters:
- N_REQ, 4, number of requesters (min 2).
- ID_WIDTH, 2, width of requester ID; must equal clog2(N_REQ).
- CNT_WIDTH, 16, width of the completed-job counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset asserted).
- req_empty_n  input  N_REQ  per-requester start FIFO non-empty flag.
- req_read  output  N_REQ  per-requester FIFO pop strobe; one-hot or zero.
- ap_start  output  1  start to shared process.
- ap_ready  input  1  shared process accepted start.
- ap_done  input  1  shared process finished.
- grant_id  output  ID_WIDTH  ID of requester currently being served.
- done_full_n  input  1  downstream FIFO not full.
- done_write  output  1  push to downstream FIFO.
- done_din  output  ID_WIDTH  pushed data; equals grant_id.
- busy  output  1  high in any state other than IDLE.
- job_count  output  CNT_WIDTH  number of completed jobs; saturating.

Behaviour:
- Reset (reset==0 at a rising edge) forces:
  - state IDLE;
  - last_grant = N_REQ-1, so requester 0 wins first;
  - grant_id = 0, job_count = 0;
  - req_read, ap_start, done_write and busy all 0.
- Reset overrides every other event.
- States are IDLE, START, RUN and NOTIFY.
- IDLE:
  - If any req_empty_n bit is set, select the first set bit scanning from last_grant+1 upward, wrapping modulo N_REQ.
  - Assert req_read for that bit combinationally in the same cycle, register grant_id, and go to START.
  - If no bit is set, stay in IDLE.
  - req_read is never asserted outside IDLE.
- START:
  - ap_start = 1.
  - ap_ready=1 and ap_done=1 -> NOTIFY.
  - ap_ready=1 only -> RUN.
  - Neither -> stay in START.
  - ap_done without ap_ready is ignored.
- RUN:
  - ap_start = 0.
  - ap_done=1 -> NOTIFY; otherwise wait indefinitely. There is no timeout.
- NOTIFY:
  - done_din = grant_id; done_write = done_full_n.
  - If done_full_n=1: last_grant <= grant_id, job_count increments (saturates at all-ones, no wrap), go to IDLE.
  - If done_full_n=0: hold in NOTIFY with done_write=0.
- ap_done in IDLE or NOTIFY is ignored.
- Latency:
  - Token visible in IDLE at cycle t -> req_read at t, ap_start at t+1.
  - Minimum per-job period is 3 cycles (IDLE, START with ready+done, NOTIFY).
- Fairness: a requester with a continuously pending token is served within N_REQ jobs.
- grant_id and done_din are registered and stable from START through NOTIFY.
- Reset mid-operation: the popped token and the in-flight job are dropped; no done push occurs. The shared process is reset by the same reset.
- Arbitration is purely combinational from req_empty_n and last_grant. The pop uses the FIFO read/read_ce=1 convention.

Test Plan:
- Reset release with req_empty_n=4'b0000 -> stays IDLE, all outputs 0, busy=0, job_count=0.
- req_empty_n=4'b1111 held, ap_ready=ap_done=1 same cycle as ap_start, done_full_n=1 -> grant order 0,1,2,3,0; one job every 3 cycles; done_din sequence 0,1,2,3; job_count=5 after 15 cycles.
- Single request on bit 2, ap_ready after 2 cycles, ap_done 5 cycles later -> req_read=4'b0100 for 1 cycle; ap_start high 3 cycles; done_write 1 cycle after ap_done with done_din=2.
- Job complete with done_full_n=0 for 4 cycles -> holds in NOTIFY, done_write=0, grant_id stable; push occurs in the cycle done_full_n returns to 1.
- reset driven 0 during RUN -> next cycle state IDLE, ap_start=0, no done_write; next grant goes to requester 0.
- CNT_WIDTH=2, 5 completed jobs -> job_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/kernel_cc_start_arbiter.sv
// kernel_cc_start_arbiter
//
// Round-robin scheduler that shares one HLS dataflow process among N_REQ
// producers. Each producer signals work through a 1-bit start-token FIFO.
// The arbiter pops one token, runs the shared process once through its
// ap_start/ap_ready/ap_done handshake, then pushes the served requester's
// ID into the downstream start/ID FIFO.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous reset, active-low
//   req_empty_n  per-requester start FIFO non-empty flags
//   req_read     per-requester FIFO pop strobe (one-hot or zero, IDLE only)
//   ap_start     start to the shared process
//   ap_ready     shared process accepted start
//   ap_done      shared process finished
//   grant_id     ID of the requester being served
//   done_full_n  downstream FIFO not full
//   done_write   push strobe to the downstream FIFO
//   done_din     pushed data (same as grant_id)
//   busy         high whenever the FSM is not in IDLE
//   job_count    completed jobs, saturating
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a token; pops the round-robin winner
// START  | ap_start high until the shared process accepts it
// RUN    | process accepted, waiting for ap_done
// NOTIFY | pushing grant_id downstream, held while the FIFO is full

module kernel_cc_start_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_WIDTH  = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_empty_n,
  output logic [N_REQ-1:0]     req_read,
  output logic                 ap_start,
  input  logic                 ap_ready,
  input  logic                 ap_done,
  output logic [ID_WIDTH-1:0]  grant_id,
  input  logic                 done_full_n,
  output logic                 done_write,
  output logic [ID_WIDTH-1:0]  done_din,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] job_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_RUN    = 2'd2,
    ST_NOTIFY = 2'd3
  } state_t;

  state_t               state;
  logic [ID_WIDTH-1:0]  last_grant;
  logic [ID_WIDTH-1:0]  grant_id_q;
  logic [CNT_WIDTH-1:0] job_count_q;
  logic                 ap_start_q;
  logic                 busy_q;

  logic                 pick_valid;
  logic [ID_WIDTH-1:0]  pick_id;
  logic [N_REQ-1:0]     pick_onehot;

  // Scan starts one past the last served requester and wraps, so the most
  // recently served requester has the lowest priority next round.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_grant) + i) % N_REQ;
      if (!pick_valid && req_empty_n[ID_WIDTH'(idx)]) begin
        pick_valid = 1'b1;
        pick_id    = ID_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    pick_onehot = '0;
    pick_onehot[pick_id] = 1'b1;
  end

  // Pop happens in the same cycle the winner is chosen, so the token is
  // consumed exactly when the FSM commits to serving it.
  assign req_read   = (state == ST_IDLE && pick_valid) ? pick_onehot : '0;
  assign done_write = (state == ST_NOTIFY) && done_full_n;
  assign done_din   = grant_id_q;
  assign grant_id   = grant_id_q;
  assign ap_start   = ap_start_q;
  assign busy       = busy_q;
  assign job_count  = job_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      last_grant  <= ID_WIDTH'(N_REQ - 1);
      grant_id_q  <= '0;
      job_count_q <= '0;
      ap_start_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_id_q <= pick_id;
            ap_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state      <= ST_START;
          end
        end
        ST_START: begin
          // ap_done without ap_ready is not a valid completion here.
          if (ap_ready) begin
            ap_start_q <= 1'b0;
            state      <= ap_done ? ST_NOTIFY : ST_RUN;
          end
        end
        ST_RUN: begin
          if (ap_done) begin
            state <= ST_NOTIFY;
          end
        end
        ST_NOTIFY: begin
          if (done_full_n) begin
            last_grant <= grant_id_q;
            if (job_count_q != {CNT_WIDTH{1'b1}}) begin
              job_count_q <= job_count_q + 1'b1;
            end
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          ap_start_q <= 1'b0;
          busy_q     <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_cc_start_arbiter.sv
// Testbench for kernel_cc_start_arbiter: per-cycle vector table covering
// reset, round-robin order, handshake latencies, downstream back-pressure,
// mid-job reset and counter saturation (second instance with CNT_WIDTH=2),
// followed by a hand-written fairness run with bounded waits.

module tb_kernel_cc_start_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_empty_n;
  logic [3:0]  req_read;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic [1:0]  grant_id;
  logic        done_full_n;
  logic        done_write;
  logic [1:0]  done_din;
  logic        busy;
  logic [15:0] job_count;

  logic [3:0]  s_req_read;
  logic        s_ap_start;
  logic [1:0]  s_grant_id;
  logic        s_done_write;
  logic [1:0]  s_done_din;
  logic        s_busy;
  logic [1:0]  s_job_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  kernel_cc_start_arbiter #(.N_REQ(4), .ID_WIDTH(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .req_empty_n(req_empty_n), .req_read(req_read),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .grant_id(grant_id), .done_full_n(done_full_n), .done_write(done_write),
    .done_din(done_din), .busy(busy), .job_count(job_count)
  );

  kernel_cc_start_arbiter #(.N_REQ(4), .ID_WIDTH(2), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .req_empty_n(req_empty_n), .req_read(s_req_read),
    .ap_start(s_ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
    .grant_id(s_grant_id), .done_full_n(done_full_n), .done_write(s_done_write),
    .done_din(s_done_din), .busy(s_busy), .job_count(s_job_count)
  );

  typedef struct {
    logic        rst_n;
    logic [3:0]  req;
    logic        rdy;
    logic        dn;
    logic        full_n;
    logic [3:0]  e_rr;
    logic        e_st;
    logic        e_dw;
    logic [1:0]  e_gid;
    logic        e_busy;
    logic [15:0] e_jc;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic rst_n, input logic [3:0] req, input logic rdy,
                      input logic dn, input logic full_n, input logic [3:0] e_rr,
                      input logic e_st, input logic e_dw, input logic [1:0] e_gid,
                      input logic e_busy, input logic [15:0] e_jc);
    vec_t v;
    v.rst_n = rst_n; v.req = req; v.rdy = rdy; v.dn = dn; v.full_n = full_n;
    v.e_rr = e_rr; v.e_st = e_st; v.e_dw = e_dw; v.e_gid = e_gid;
    v.e_busy = e_busy; v.e_jc = e_jc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_sat;
    int          waited;
    bit          found;

    // reset release, idle with no requests
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 2'd0, 0, 16'd0);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 2'd0, 0, 16'd0);
    // all requesting, ready+done with start: 3-cycle jobs, order 0,1,2,3,0
    addv(1, 4'b1111, 1, 1, 1, 4'b0001, 0, 0, 2'd0, 0, 16'd0);
    addv(1, 4'b1111, 1, 1, 1, 4'b0000, 1, 0, 2'd0, 1, 16'd0);
    addv(1, 4'b1111, 1, 1, 1, 4'b0000, 0, 1, 2'd0, 1, 16'd0);
    addv(1, 4'b1111, 1, 1, 1, 4'b0010, 0, 0, 2'd0, 0, 16'd1);
    addv(1, 4'b1111, 1, 1, 1, 4'b0000, 1, 0, 2'd1, 1, 16'd1);
    addv(1, 4'b1111, 1, 1, 1, 4'b0000, 0, 1, 2'd1, 1, 16'd1);
    addv(1, 4'b1111, 1, 1, 1, 4'b0100, 0, 0, 2'd1, 0, 16'd2);
    addv(1, 4'b1111, 1, 1, 1, 4'b0000, 1, 0, 2'd2, 1, 16'd2);
    addv(1, 4'b1111, 1, 1, 1, 4'b0000, 0, 1, 2'd2, 1, 16'd2);
    addv(1, 4'b1111, 1, 1, 1, 4'b1000, 0, 0, 2'd2, 0, 16'd3);
    addv(1, 4'b1111, 1, 1, 1, 4'b0000, 1, 0, 2'd3, 1, 16'd3);
    addv(1, 4'b1111, 1, 1, 1, 4'b0000, 0, 1, 2'd3, 1, 16'd3);
    addv(1, 4'b1111, 1, 1, 1, 4'b0001, 0, 0, 2'd3, 0, 16'd4);
    addv(1, 4'b1111, 1, 1, 1, 4'b0000, 1, 0, 2'd0, 1, 16'd4);
    addv(1, 4'b1111, 1, 1, 1, 4'b0000, 0, 1, 2'd0, 1, 16'd4);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 2'd0, 0, 16'd5);
    // single request on bit 2, ready after 2 cycles, done 5 cycles later
    addv(1, 4'b0100, 0, 0, 1, 4'b0100, 0, 0, 2'd0, 0, 16'd5);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 1, 0, 2'd2, 1, 16'd5);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 1, 0, 2'd2, 1, 16'd5);
    addv(1, 4'b0000, 1, 0, 1, 4'b0000, 1, 0, 2'd2, 1, 16'd5);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 2'd2, 1, 16'd5);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 2'd2, 1, 16'd5);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 2'd2, 1, 16'd5);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 2'd2, 1, 16'd5);
    addv(1, 4'b0000, 0, 1, 1, 4'b0000, 0, 0, 2'd2, 1, 16'd5);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 1, 2'd2, 1, 16'd5);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 2'd2, 0, 16'd6);
    // wrap from last_grant=2 past empty bit 3 to bit 0; downstream full 4 cycles
    addv(1, 4'b0011, 1, 1, 0, 4'b0001, 0, 0, 2'd2, 0, 16'd6);
    addv(1, 4'b0000, 1, 1, 0, 4'b0000, 1, 0, 2'd0, 1, 16'd6);
    addv(1, 4'b0000, 1, 1, 0, 4'b0000, 0, 0, 2'd0, 1, 16'd6);
    addv(1, 4'b0000, 1, 1, 0, 4'b0000, 0, 0, 2'd0, 1, 16'd6);
    addv(1, 4'b0000, 1, 1, 0, 4'b0000, 0, 0, 2'd0, 1, 16'd6);
    addv(1, 4'b0000, 1, 1, 0, 4'b0000, 0, 0, 2'd0, 1, 16'd6);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 1, 2'd0, 1, 16'd6);
    // ap_done in IDLE ignored
    addv(1, 4'b0000, 0, 1, 1, 4'b0000, 0, 0, 2'd0, 0, 16'd7);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 2'd0, 0, 16'd7);
    // reset during RUN drops the job; next grant from requester 0
    addv(1, 4'b0100, 0, 0, 1, 4'b0100, 0, 0, 2'd0, 0, 16'd7);
    addv(1, 4'b0000, 1, 0, 1, 4'b0000, 1, 0, 2'd2, 1, 16'd7);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 2'd2, 1, 16'd7);
    addv(0, 4'b0000, 0, 1, 1, 4'b0000, 0, 0, 2'd2, 1, 16'd7);
    addv(1, 4'b1111, 0, 0, 1, 4'b0001, 0, 0, 2'd0, 0, 16'd0);
    addv(1, 4'b0000, 1, 1, 1, 4'b0000, 1, 0, 2'd0, 1, 16'd0);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 1, 2'd0, 1, 16'd0);
    addv(1, 4'b0000, 0, 0, 1, 4'b0000, 0, 0, 2'd0, 0, 16'd1);

    reset       = 1'b0;
    req_empty_n = 4'b0000;
    ap_ready    = 1'b0;
    ap_done     = 1'b0;
    done_full_n = 1'b1;
    #1;
    repeat (2) next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      reset       = vecs[i].rst_n;
      req_empty_n = vecs[i].req;
      ap_ready    = vecs[i].rdy;
      ap_done     = vecs[i].dn;
      done_full_n = vecs[i].full_n;
      @(negedge clk);
      exp_sat = (vecs[i].e_jc > 16'd3) ? 16'd3 : vecs[i].e_jc;
      chk("req_read",   i, 32'(req_read),   32'(vecs[i].e_rr));
      chk("ap_start",   i, 32'(ap_start),   32'(vecs[i].e_st));
      chk("done_write", i, 32'(done_write), 32'(vecs[i].e_dw));
      chk("grant_id",   i, 32'(grant_id),   32'(vecs[i].e_gid));
      chk("done_din",   i, 32'(done_din),   32'(vecs[i].e_gid));
      chk("busy",       i, 32'(busy),       32'(vecs[i].e_busy));
      chk("job_count",  i, 32'(job_count),  32'(vecs[i].e_jc));
      chk("sat_count",  i, 32'(s_job_count), 32'(exp_sat));
      next_cycle();
    end

    // fairness: all pending, last served was 0 -> order 1,2,3,0 with
    // intermittent back-pressure
    reset       = 1'b1;
    req_empty_n = 4'b1111;
    ap_ready    = 1'b1;
    ap_done     = 1'b1;
    for (int j = 0; j < 4; j++) begin
      waited = 0;
      found  = 1'b0;
      while (!found && waited < 20) begin
        done_full_n = (waited % 2 == 1);
        @(negedge clk);
        chk("req_read_onehot", 100 + j, 32'($countones(req_read) <= 1), 32'd1);
        if (done_write) begin
          found = 1'b1;
          chk("fair_din", 100 + j, 32'(done_din), 32'((j + 1) % 4));
        end
        next_cycle();
        waited++;
      end
      if (!found) begin
        n_checks++;
        n_fail++;
        $display("FAIL fair_timeout job %0d: no done_write within 20 cycles", j);
      end
    end
    req_empty_n = 4'b0000;
    done_full_n = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("fair_job_count", 200, 32'(job_count), 32'd5);
    chk("fair_sat_count", 200, 32'(s_job_count), 32'd3);
    chk("fair_idle_busy", 200, 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
